axi_read_burst_generator: RTL and testbench
===========================================

Name: axi_read_burst_generator

Overview:
- Converts beat-granular read requests (start address, beat count) from a DMA/stream engine into AXI4 INCR read bursts.
- Drives the master modport of axi_read_address_channel.
- Splits each request at 4 KiB boundaries and at MAX_BURST_BEATS.
- Limits in-flight bursts using read-completion pulses from the downstream R-channel consumer.

Parameters:
- AXI_ARID_WIDTH, 1, width of arid.
- AXI_ARADDR_WIDTH, 32, address width.
- AXI_ARUSER_WIDTH, 0, aruser width; aruser driven all-zero.
- DATA_BYTES, 8, bytes per beat; power of two, 1..128.
- MAX_BURST_BEATS, 16, maximum beats per burst; power of two, 1..256.
- MAX_OUTSTANDING, 4, maximum issued-but-uncompleted bursts; at least 1.
- BEATS_WIDTH, 16, width of req_beats.
- ARID_VALUE, 0, constant driven on arid.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_addr  in  AXI_ARADDR_WIDTH  start address; must be DATA_BYTES-aligned.
- req_beats  in  BEATS_WIDTH  number of beats; 0 is legal.
- burst_done  in  1  one pulse per completed burst (rvalid & rready & rlast, from the R consumer).
- busy  out  1  high while a request is in progress or any burst is outstanding.
- m_axi_ar  interface  axi_read_address_channel.master  AR channel to the interconnect.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, outstanding=0, arvalid=0, req_ready=0 during reset and 1 in the first cycle after, busy=0.
  - Latched address and remaining count are cleared.
- Constant AR fields:
  - arid=ARID_VALUE, arsize=log2(DATA_BYTES), arburst=INCR (2'b01).
  - arlock=0, arcache=4'b0011, arprot=0, arqos=0, arregion=0, aruser=0.
- IDLE:
  - req_ready=1. On handshake, latch cur_addr=req_addr and remaining=req_beats.
  - remaining==0: stay IDLE; no AR is issued. Otherwise go to CALC.
- CALC:
  - Register to_boundary = (4096 - cur_addr[11:0]) / DATA_BYTES, range 1..4096/DATA_BYTES.
  - Register burst_beats = min(remaining, MAX_BURST_BEATS, to_boundary).
  - Stay in CALC while outstanding == MAX_OUTSTANDING. Otherwise go to ISSUE.
- ISSUE:
  - arvalid=1, araddr=cur_addr, arlen=burst_beats-1.
  - All AR fields stay stable until arready is seen.
  - On handshake: cur_addr += burst_beats*DATA_BYTES and remaining -= burst_beats.
  - Then go to IDLE if the new remaining is 0, else to CALC.
  - arvalid never deasserts without a handshake, except under reset.
- Latency:
  - Request handshake at cycle N; arvalid first high at N+2 if not throttled.
  - Back-to-back bursts of one request are 2 cycles apart with arready held high.
- Outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - Increments on AR handshake and decrements on burst_done.
  - Both in the same cycle: unchanged.
  - burst_done with outstanding==0 is a protocol error: counter saturates at 0 and a simulation assertion fires.
- Throttle check uses the registered counter value. A burst_done in the CALC cycle releases the stall one cycle later.
- busy = (state != IDLE) | (outstanding != 0).
- A new request may be accepted while earlier bursts are still outstanding.
- Address arithmetic wraps modulo 2^AXI_ARADDR_WIDTH. A 4 KiB split never produces a crossing burst.
- Reset mid-burst: arvalid drops on the next clock edge and the outstanding count is lost. Resetting the interconnect alongside is the system's responsibility.

Decomposition:
- Shared package axi_pkg holds:
  - burst type constants (FIXED/INCR/WRAP);
  - arcache encodings;
  - function size_from_bytes(DATA_BYTES) returning arsize;
  - constant AXI_4K_BYTES = 4096.
- State enum {IDLE, CALC, ISSUE} stays local to the module.
- No sub-module. The burst-length min() is inline combinational logic feeding a register.

Test Plan (DATA_BYTES=8, MAX_BURST_BEATS=16):
- Aligned single burst: addr 0x1000, beats 16 → exactly one AR (araddr 0x1000, arlen 15, arsize 3, arburst 1) with arvalid at cycle N+2.
- 4 KiB split: addr 0x1FC0, beats 20 → ARs (0x1FC0, arlen 7) then (0x2000, arlen 11); no further AR.
- Max-burst split: addr 0x0, beats 40 → ARs (0x000, len 15), (0x080, len 15), (0x100, len 7).
- Backpressure: arready low for 5 cycles during ISSUE → arvalid, araddr and arlen constant across all 5 cycles; handshake on the 6th; counter increments once.
- Throttle (MAX_OUTSTANDING=2): addr 0x0, beats 64, no burst_done → two ARs, then arvalid stays 0. A single burst_done pulse → third AR (0x100, len 15) appears within 3 cycles. Simultaneous handshake and burst_done leave the count unchanged.
- Zero-length request, and reset in ISSUE:
  - beats 0 → no AR, req_ready high again the next cycle, busy stays 0.
  - reset asserted during ISSUE → arvalid=0, busy=0, req_ready=1 in the first cycle after reset releases.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI constants and helpers used by the AR-channel burst generator.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [3:0] AXI_ARCACHE_DEVICE_NONBUF        = 4'b0000;
  localparam logic [3:0] AXI_ARCACHE_DEVICE_BUF           = 4'b0001;
  localparam logic [3:0] AXI_ARCACHE_NORMAL_NONCACHE      = 4'b0010;
  localparam logic [3:0] AXI_ARCACHE_NORMAL_NONCACHE_BUF  = 4'b0011;

  localparam int unsigned AXI_4K_BYTES = 4096;

  // AxSIZE encoding for a power-of-two beat width in bytes
  function automatic logic [2:0] size_from_bytes(input int unsigned bytes);
    logic [2:0] size;
    size = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/axi_read_address_channel.sv
// AXI4 read-address channel bundle with master/slave views.
interface axi_read_address_channel #(
  parameter int unsigned AXI_ARID_WIDTH   = 1,
  parameter int unsigned AXI_ARADDR_WIDTH = 32,
  parameter int unsigned AXI_ARUSER_WIDTH = 0
);
  // A zero-width user field is carried as one tied-off bit
  localparam int unsigned USER_W = (AXI_ARUSER_WIDTH > 0) ? AXI_ARUSER_WIDTH : 1;

  logic [AXI_ARID_WIDTH-1:0]   arid;
  logic [AXI_ARADDR_WIDTH-1:0] araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arlock;
  logic [3:0]                  arcache;
  logic [2:0]                  arprot;
  logic [3:0]                  arqos;
  logic [3:0]                  arregion;
  logic [USER_W-1:0]           aruser;
  logic                        arvalid;
  logic                        arready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache,
           arprot, arqos, arregion, aruser, arvalid,
    input  arready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache,
           arprot, arqos, arregion, aruser, arvalid,
    output arready
  );

endinterface

// File: rtl/axi_read_burst_generator.sv
// Turns beat-granular read requests into AXI4 INCR bursts, split at 4 KiB and
// MAX_BURST_BEATS, with the number of in-flight bursts capped by MAX_OUTSTANDING.
module axi_read_burst_generator
  import axi_pkg::*;
#(
  parameter int unsigned AXI_ARID_WIDTH   = 1,
  parameter int unsigned AXI_ARADDR_WIDTH = 32,
  parameter int unsigned AXI_ARUSER_WIDTH = 0,
  parameter int unsigned DATA_BYTES       = 8,
  parameter int unsigned MAX_BURST_BEATS  = 16,
  parameter int unsigned MAX_OUTSTANDING  = 4,
  parameter int unsigned BEATS_WIDTH      = 16,
  parameter int unsigned ARID_VALUE       = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [AXI_ARADDR_WIDTH-1:0] req_addr,
  input  logic [BEATS_WIDTH-1:0]      req_beats,
  input  logic                        burst_done,
  output logic                        busy,
  axi_read_address_channel.master     m_axi_ar
);

  localparam int unsigned AW     = AXI_ARADDR_WIDTH;
  localparam int unsigned SHIFT  = $clog2(DATA_BYTES);
  localparam int unsigned BB_W   = $clog2(MAX_BURST_BEATS + 1);
  localparam int unsigned TB_W   = 13;
  localparam int unsigned CW     = (BEATS_WIDTH > TB_W) ? BEATS_WIDTH : TB_W;
  localparam int unsigned OW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned USER_W = (AXI_ARUSER_WIDTH > 0) ? AXI_ARUSER_WIDTH : 1;
  localparam logic [2:0]  AR_SIZE = size_from_bytes(DATA_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ISSUE
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          cur_addr_q, cur_addr_d;
  logic [BEATS_WIDTH-1:0] remaining_q, remaining_d;
  logic [BB_W-1:0]        burst_beats_q, burst_beats_d;
  logic [7:0]             arlen_q, arlen_d;
  logic [OW-1:0]          outstanding_q, outstanding_d;
  logic                   arvalid_q;
  logic                   req_ready_q;
  logic                   busy_q;

  logic [CW-1:0]          to_boundary;
  logic [CW-1:0]          beat_min;
  logic                   ar_hs;

  assign ar_hs = arvalid_q & m_axi_ar.arready;

  // Beats left before the next 4 KiB page, and the resulting burst size
  always_comb begin
    to_boundary = CW'(TB_W'(TB_W'(AXI_4K_BYTES) - {1'b0, cur_addr_q[11:0]}) >> SHIFT);
    beat_min    = CW'(remaining_q);
    if (beat_min > CW'(MAX_BURST_BEATS)) beat_min = CW'(MAX_BURST_BEATS);
    if (beat_min > to_boundary)          beat_min = to_boundary;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    burst_beats_d = burst_beats_q;
    arlen_d       = arlen_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          cur_addr_d  = req_addr;
          remaining_d = req_beats;
          if (req_beats != '0) state_d = CALC;
        end
      end
      CALC: begin
        burst_beats_d = BB_W'(beat_min);
        arlen_d       = 8'(beat_min - CW'(1));
        if (outstanding_q != OW'(MAX_OUTSTANDING)) state_d = ISSUE;
      end
      ISSUE: begin
        if (ar_hs) begin
          cur_addr_d  = cur_addr_q + (AW'(burst_beats_q) << SHIFT);
          remaining_d = remaining_q - BEATS_WIDTH'(burst_beats_q);
          state_d     = (remaining_d == '0) ? IDLE : CALC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In-flight burst count; a handshake and a completion together cancel out
  always_comb begin
    outstanding_d = outstanding_q;
    if (ar_hs && !burst_done) begin
      outstanding_d = outstanding_q + OW'(1);
    end else if (!ar_hs && burst_done && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - OW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      burst_beats_q <= '0;
      arlen_q       <= '0;
      outstanding_q <= '0;
      arvalid_q     <= 1'b0;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      burst_beats_q <= burst_beats_d;
      arlen_q       <= arlen_d;
      outstanding_q <= outstanding_d;
      arvalid_q     <= (state_d == ISSUE);
      req_ready_q   <= (state_d == IDLE);
      busy_q        <= (state_d != IDLE) || (outstanding_d != '0);
    end
  end

  // A completion with nothing in flight means the R consumer is out of step
  assert property (@(posedge clock) disable iff (reset)
    !(burst_done && (outstanding_q == '0)));

  assign req_ready = req_ready_q;
  assign busy      = busy_q;

  assign m_axi_ar.arid     = AXI_ARID_WIDTH'(ARID_VALUE);
  assign m_axi_ar.araddr   = cur_addr_q;
  assign m_axi_ar.arlen    = arlen_q;
  assign m_axi_ar.arsize   = AR_SIZE;
  assign m_axi_ar.arburst  = AXI_BURST_INCR;
  assign m_axi_ar.arlock   = 1'b0;
  assign m_axi_ar.arcache  = AXI_ARCACHE_NORMAL_NONCACHE_BUF;
  assign m_axi_ar.arprot   = 3'b000;
  assign m_axi_ar.arqos    = 4'b0000;
  assign m_axi_ar.arregion = 4'b0000;
  assign m_axi_ar.aruser   = USER_W'(0);
  assign m_axi_ar.arvalid  = arvalid_q;

endmodule

// File: tb/tb_axi_read_burst_generator.sv
// Self-checking bench for axi_read_burst_generator (8-byte beats, 16-beat bursts, 2 in flight).
module tb_axi_read_burst_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [15:0] req_beats;
  logic        burst_done;
  logic        busy;
  logic        arready;

  always #5 clk = ~clk;

  axi_read_address_channel #(.AXI_ARID_WIDTH(1), .AXI_ARADDR_WIDTH(32), .AXI_ARUSER_WIDTH(0)) ar_if ();
  assign ar_if.arready = arready;

  axi_read_burst_generator #(
    .AXI_ARID_WIDTH(1), .AXI_ARADDR_WIDTH(32), .AXI_ARUSER_WIDTH(0), .DATA_BYTES(8),
    .MAX_BURST_BEATS(16), .MAX_OUTSTANDING(2), .BEATS_WIDTH(16), .ARID_VALUE(0)
  ) dut (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_beats(req_beats), .burst_done(burst_done), .busy(busy),
    .m_axi_ar(ar_if.master)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  cache;
    int          cyc;
  } ar_rec_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          beats;
    int          n;
    logic [31:0] a0; logic [7:0] l0;
    logic [31:0] a1; logic [7:0] l1;
    logic [31:0] a2; logic [7:0] l2;
  } vec_t;

  ar_rec_t hs_q[$];
  exp_t    exp_q[$];
  int      mon_cyc  = 0;
  int      stab_err = 0;
  int      n_checks = 0;
  int      n_fail   = 0;
  int      done_count = 0;
  bit      auto_done  = 1'b0;
  bit      rand_ready = 1'b0;

  // Observer: records every AR handshake and flags any change while stalled
  logic        prev_v = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_a = '0;
  logic [7:0]  prev_l = '0;
  always @(negedge clk) begin
    mon_cyc++;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_hs &&
          (!ar_if.arvalid || ar_if.araddr !== prev_a || ar_if.arlen !== prev_l)) stab_err++;
      if (ar_if.arvalid && arready)
        hs_q.push_back('{ar_if.araddr, ar_if.arlen, ar_if.arsize, ar_if.arburst, ar_if.arcache, mon_cyc});
      prev_v  = ar_if.arvalid;
      prev_hs = ar_if.arvalid && arready;
      prev_a  = ar_if.araddr;
      prev_l  = ar_if.arlen;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    burst_done = 1'b0;
    if (auto_done && (hs_q.size() > done_count) && ($urandom_range(0, 2) == 0)) begin
      burst_done = 1'b1;
      done_count++;
    end
    if (rand_ready) arready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic pulse_now();
    burst_done = 1'b1;
    done_count++;
  endtask

  task automatic send_req(input logic [31:0] a, input int b, output int rc);
    int g;
    g = 0;
    req_addr  = a;
    req_beats = 16'(b);
    req_valid = 1'b1;
    rc = mon_cyc + 1;
    while (!req_ready && g < 200) begin
      step();
      g++;
      rc = mon_cyc + 1;
    end
    check("req_accept", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (busy && g < 2000) begin
      step();
      g++;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_arvalid(input string tag);
    int g;
    g = 0;
    while (!ar_if.arvalid && g < 20) begin
      step();
      g++;
    end
    check({tag, "_arvalid"}, 64'(ar_if.arvalid), 64'd1);
  endtask

  // Reference: walk the request page by page with plain arithmetic
  task automatic model_bursts(input logic [31:0] a, input int b);
    int room, n;
    exp_q.delete();
    while (b > 0) begin
      room = (4096 - int'(a % 32'd4096)) / 8;
      n = b;
      if (n > 16)   n = 16;
      if (n > room) n = room;
      exp_q.push_back('{a, 8'(n - 1)});
      a = a + 32'(n * 8);
      b = b - n;
    end
  endtask

  task automatic compare_bursts(input string tag, input int base);
    check({tag, "_count"}, 64'(hs_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (base + i) < hs_q.size(); i++) begin
      check({tag, "_addr"},  64'(hs_q[base + i].addr),  64'(exp_q[i].addr));
      check({tag, "_len"},   64'(hs_q[base + i].len),   64'(exp_q[i].len));
      check({tag, "_size"},  64'(hs_q[base + i].size),  64'd3);
      check({tag, "_burst"}, 64'(hs_q[base + i].burst), 64'd1);
      check({tag, "_cache"}, 64'(hs_q[base + i].cache), 64'd3);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[6];
    int          rc, base, g;
    logic [31:0] ra;
    int          rb;

    vecs[0] = '{32'h0000_1000, 16, 1, 32'h0000_1000, 8'd15, 32'h0, 8'd0, 32'h0, 8'd0};
    vecs[1] = '{32'h0000_1FC0, 20, 2, 32'h0000_1FC0, 8'd7,  32'h0000_2000, 8'd11, 32'h0, 8'd0};
    vecs[2] = '{32'h0000_0000, 40, 3, 32'h0000_0000, 8'd15, 32'h0000_0080, 8'd15, 32'h0000_0100, 8'd7};
    vecs[3] = '{32'h0000_0FF8, 3,  2, 32'h0000_0FF8, 8'd0,  32'h0000_1000, 8'd1,  32'h0, 8'd0};
    vecs[4] = '{32'hFFFF_FFF0, 4,  2, 32'hFFFF_FFF0, 8'd1,  32'h0000_0000, 8'd1,  32'h0, 8'd0};
    vecs[5] = '{32'h0000_7F80, 17, 2, 32'h0000_7F80, 8'd15, 32'h0000_8000, 8'd0,  32'h0, 8'd0};

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_beats = '0;
    burst_done = 1'b0; arready = 1'b0;

    // Reset values and constant AR fields
    repeat (3) step();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_arvalid",   64'(ar_if.arvalid), 64'd0);
    check("rst_busy",      64'(busy), 64'd0);
    reset = 1'b0;
    step();
    check("post_rst_req_ready", 64'(req_ready), 64'd1);
    check("post_rst_busy",      64'(busy), 64'd0);
    check("arid",     64'(ar_if.arid), 64'd0);
    check("arlock",   64'(ar_if.arlock), 64'd0);
    check("arprot",   64'(ar_if.arprot), 64'd0);
    check("arqos",    64'(ar_if.arqos), 64'd0);
    check("arregion", 64'(ar_if.arregion), 64'd0);
    check("aruser",   64'(ar_if.aruser), 64'd0);
    check("arcache",  64'(ar_if.arcache), 64'd3);

    // Directed splits from the vector table
    arready = 1'b1; auto_done = 1'b1;
    for (int v = 0; v < 6; v++) begin
      exp_q.delete();
      exp_q.push_back('{vecs[v].a0, vecs[v].l0});
      if (vecs[v].n > 1) exp_q.push_back('{vecs[v].a1, vecs[v].l1});
      if (vecs[v].n > 2) exp_q.push_back('{vecs[v].a2, vecs[v].l2});
      base = hs_q.size();
      send_req(vecs[v].addr, vecs[v].beats, rc);
      wait_idle($sformatf("vec%0d", v));
      compare_bursts($sformatf("vec%0d", v), base);
      if (v == 0 && hs_q.size() > base)
        check("first_ar_latency", 64'(hs_q[base].cyc - rc), 64'd2);
      if (v == 2 && hs_q.size() > base + 1)
        check("back_to_back_gap", 64'(hs_q[base + 1].cyc - hs_q[base].cyc), 64'd2);
    end

    // Zero-length request
    base = hs_q.size();
    send_req(32'h0000_0040, 0, rc);
    check("zero_req_ready", 64'(req_ready), 64'd1);
    check("zero_busy",      64'(busy), 64'd0);
    repeat (5) step();
    check("zero_busy_later", 64'(busy), 64'd0);
    check("zero_no_ar",      64'(hs_q.size() - base), 64'd0);

    // Backpressure: five stalled cycles, handshake on the sixth
    auto_done = 1'b0; arready = 1'b0;
    base = hs_q.size();
    send_req(32'h0000_3000, 4, rc);
    wait_arvalid("bp");
    for (int i = 0; i < 5; i++) begin
      check("bp_arvalid", 64'(ar_if.arvalid), 64'd1);
      check("bp_araddr",  64'(ar_if.araddr), 64'h3000);
      check("bp_arlen",   64'(ar_if.arlen), 64'd3);
      step();
    end
    check("bp_still_valid", 64'(ar_if.arvalid), 64'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    repeat (3) step();
    check("bp_one_ar", 64'(hs_q.size() - base), 64'd1);
    check("bp_busy_outstanding", 64'(busy), 64'd1);
    if (busy) pulse_now();
    step();
    check("bp_busy_released", 64'(busy), 64'd0);

    // Throttle at two in flight, release, and simultaneous handshake + completion
    arready = 1'b1;
    base = hs_q.size();
    send_req(32'h0000_0000, 64, rc);
    repeat (12) step();
    check("thr_two_issued", 64'(hs_q.size() - base), 64'd2);
    check("thr_stalled",    64'(ar_if.arvalid), 64'd0);
    check("thr_busy",       64'(busy), 64'd1);
    pulse_now();
    g = 0;
    while ((hs_q.size() - base) < 3 && g < 3) begin
      step();
      g++;
    end
    check("thr_third_in_3", 64'(hs_q.size() - base), 64'd3);
    if (hs_q.size() - base >= 3) begin
      check("thr_third_addr", 64'(hs_q[base + 2].addr), 64'h100);
      check("thr_third_len",  64'(hs_q[base + 2].len), 64'd15);
    end
    repeat (4) step();
    check("thr_stalled2", 64'(hs_q.size() - base), 64'd3);
    pulse_now();
    step();
    wait_arvalid("thr4");
    pulse_now();
    step();
    repeat (3) step();
    check("thr_four_issued", 64'(hs_q.size() - base), 64'd4);
    if (hs_q.size() - base >= 4)
      check("thr_fourth_addr", 64'(hs_q[base + 3].addr), 64'h180);
    check("thr_count_kept", 64'(busy), 64'd1);
    if (busy) pulse_now();
    step();
    check("thr_drained", 64'(busy), 64'd0);

    // Reset while an AR is pending
    arready = 1'b0;
    send_req(32'h0000_0500, 8, rc);
    wait_arvalid("rst_issue");
    reset = 1'b1;
    step();
    check("rst_issue_arvalid", 64'(ar_if.arvalid), 64'd0);
    check("rst_issue_ready",   64'(req_ready), 64'd0);
    reset = 1'b0;
    step();
    check("rst_rel_arvalid", 64'(ar_if.arvalid), 64'd0);
    check("rst_rel_busy",    64'(busy), 64'd0);
    check("rst_rel_ready",   64'(req_ready), 64'd1);
    done_count = hs_q.size();

    // Randomised requests against the reference model
    auto_done = 1'b1; rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      ra = {12'($urandom), 20'd0};
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_F000;
      if ($urandom_range(0, 1) == 1) ra = ra + 32'(4096 - 8 * $urandom_range(1, 40));
      else                           ra = ra + 32'(8 * $urandom_range(0, 511));
      rb = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 70));
      model_bursts(ra, rb);
      base = hs_q.size();
      send_req(ra, rb, rc);
      wait_idle($sformatf("rnd%0d", t));
      compare_bursts($sformatf("rnd%0d", t), base);
    end
    rand_ready = 1'b0;

    check("ar_stable_while_stalled", 64'(stab_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
